// File: rtl/traffic_light_xsec.sv
// Two-approach intersection controller: green/blink/yellow/all-red per approach, latched
// crossing requests that cut the opposing green early, and a night flashing-yellow mode.
module traffic_light_xsec #(
    parameter int unsigned T_GREEN     = 1024,
    parameter int unsigned T_MIN_GREEN = 128,
    parameter int unsigned T_BLINK     = 128,
    parameter int unsigned N_BLINK     = 2,
    parameter int unsigned T_YELLOW    = 512,
    parameter int unsigned T_ALLRED    = 64,
    parameter int unsigned CW          = 11
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pass_a_i,
    input  logic       pass_b_i,
    input  logic       night_i,
    output logic       a_r_o,
    output logic       a_y_o,
    output logic       a_g_o,
    output logic       b_r_o,
    output logic       b_y_o,
    output logic       b_g_o,
    output logic [3:0] phase_o
);

    typedef enum logic [3:0] {
        StAGreen  = 4'd0,
        StABlink  = 4'd1,
        StAYellow = 4'd2,
        StRed1    = 4'd3,
        StBGreen  = 4'd4,
        StBBlink  = 4'd5,
        StBYellow = 4'd6,
        StRed2    = 4'd7,
        StNight   = 4'd8
    } state_e;

    localparam logic [CW-1:0] TGreen    = CW'(T_GREEN);
    localparam logic [CW-1:0] TMinGreen = CW'(T_MIN_GREEN);
    localparam logic [CW-1:0] TBlink    = CW'(T_BLINK);
    localparam logic [CW-1:0] TYellow   = CW'(T_YELLOW);
    localparam logic [CW-1:0] TAllred   = CW'(T_ALLRED);
    localparam logic [CW-1:0] LastHalf  = CW'(2 * N_BLINK - 1);
    localparam logic [CW-1:0] CntMax    = {CW{1'b1}};
    localparam logic [CW-1:0] One       = CW'(1);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] half_q, half_d;
    logic          pend_a_q, pend_a_d;
    logic          pend_b_q, pend_b_d;
    logic [5:0]    lamps_q, lamps_d;  // {a_r, a_y, a_g, b_r, b_y, b_g}

    always_comb begin
        state_d = state_q;
        half_d  = half_q;
        cnt_d   = (cnt_q == CntMax) ? cnt_q : cnt_q + One;

        if (night_i && state_q != StNight) begin
            state_d = StNight;
        end else begin
            unique case (state_q)
                StAGreen:  if (cnt_q == TGreen || (pend_b_q && cnt_q >= TMinGreen)) state_d = StABlink;
                StAYellow: if (cnt_q == TYellow) state_d = StRed1;
                StRed1:    if (cnt_q == TAllred) state_d = StBGreen;
                StBGreen:  if (cnt_q == TGreen || (pend_a_q && cnt_q >= TMinGreen)) state_d = StBBlink;
                StBYellow: if (cnt_q == TYellow) state_d = StRed2;
                StRed2:    if (cnt_q == TAllred) state_d = StAGreen;
                StABlink, StBBlink: begin
                    if (cnt_q == TBlink) begin
                        if (half_q == LastHalf) begin
                            state_d = (state_q == StABlink) ? StAYellow : StBYellow;
                        end else begin
                            half_d = half_q + One;
                            cnt_d  = One;
                        end
                    end
                end
                StNight: begin
                    if (!night_i) begin
                        state_d = StRed2;
                    end else if (cnt_q == TBlink) begin
                        half_d = half_q ^ One;
                        cnt_d  = One;
                    end
                end
                default: state_d = StRed2;
            endcase
        end

        if (state_d != state_q) begin
            cnt_d  = One;
            half_d = '0;
        end
    end

    always_comb begin
        pend_a_d = pend_a_q | (pass_a_i && state_q != StAGreen && state_q != StNight);
        pend_b_d = pend_b_q | (pass_b_i && state_q != StBGreen && state_q != StNight);
        if (state_d == StNight && state_q != StNight) begin
            pend_a_d = 1'b0;
            pend_b_d = 1'b0;
        end
        if (state_d == StAGreen && state_q != StAGreen) pend_a_d = 1'b0;
        if (state_d == StBGreen && state_q != StBGreen) pend_b_d = 1'b0;
    end

    // Lamps are derived from the next state so the registered outputs line up with phase_o.
    always_comb begin
        lamps_d = 6'b100_100;
        case (state_d)
            StAGreen:  lamps_d = 6'b001_100;
            StABlink:  lamps_d = {2'b00, half_d[0], 3'b100};
            StAYellow: lamps_d = 6'b010_100;
            StBGreen:  lamps_d = 6'b100_001;
            StBBlink:  lamps_d = {3'b100, 2'b00, half_d[0]};
            StBYellow: lamps_d = 6'b100_010;
            StNight:   lamps_d = {1'b0, ~half_d[0], 2'b00, ~half_d[0], 1'b0};
            default:   lamps_d = 6'b100_100;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StAGreen;
            cnt_q    <= One;
            half_q   <= '0;
            pend_a_q <= 1'b0;
            pend_b_q <= 1'b0;
            lamps_q  <= 6'b001_100;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            half_q   <= half_d;
            pend_a_q <= pend_a_d;
            pend_b_q <= pend_b_d;
            lamps_q  <= lamps_d;
        end
    end

    assign {a_r_o, a_y_o, a_g_o, b_r_o, b_y_o, b_g_o} = lamps_q;
    assign phase_o = state_q;

endmodule

// File: tb/tb_traffic_light_xsec.sv
// Bench for traffic_light_xsec: default and shortened-timing instances share stimulus and are
// each compared every cycle against a phase/elapsed-time reference model.
module tb_traffic_light_xsec;

    typedef struct {
        int ph;
        int t;
        bit pa;
        bit pb;
    } mstate_t;

    typedef struct {
        int tg;
        int tmin;
        int tb;
        int nb;
        int ty;
        int tar;
    } mparam_t;

    typedef struct {
        bit         r;
        bit         xa;
        bit         xb;
        bit         nt;
        int         n;
        logic [9:0] exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic pass_a = 1'b0;
    logic pass_b = 1'b0;
    logic night = 1'b0;

    logic       a_r_b, a_y_b, a_g_b, b_r_b, b_y_b, b_g_b;
    logic       a_r_s, a_y_s, a_g_s, b_r_s, b_y_s, b_g_s;
    logic [3:0] phase_b, phase_s;
    logic [9:0] out_big, out_sm;

    int checks = 0;
    int passes = 0;

    mstate_t ms_big, ms_sm;
    mparam_t p_big, p_sm;
    vec_t    tbl[16];

    always #5 clk = ~clk;

    traffic_light_xsec dut_big (
        .clk(clk), .rst(rst), .pass_a_i(pass_a), .pass_b_i(pass_b), .night_i(night),
        .a_r_o(a_r_b), .a_y_o(a_y_b), .a_g_o(a_g_b),
        .b_r_o(b_r_b), .b_y_o(b_y_b), .b_g_o(b_g_b), .phase_o(phase_b)
    );

    traffic_light_xsec #(
        .T_GREEN(5), .T_MIN_GREEN(3), .T_BLINK(2), .N_BLINK(1), .T_YELLOW(3), .T_ALLRED(2),
        .CW(11)
    ) dut_sm (
        .clk(clk), .rst(rst), .pass_a_i(pass_a), .pass_b_i(pass_b), .night_i(night),
        .a_r_o(a_r_s), .a_y_o(a_y_s), .a_g_o(a_g_s),
        .b_r_o(b_r_s), .b_y_o(b_y_s), .b_g_o(b_g_s), .phase_o(phase_s)
    );

    assign out_big = {phase_b, a_r_b, a_y_b, a_g_b, b_r_b, b_y_b, b_g_b};
    assign out_sm  = {phase_s, a_r_s, a_y_s, a_g_s, b_r_s, b_y_s, b_g_s};

    function automatic int phase_dur(int ph, mparam_t p);
        case (ph % 4)
            0:       return p.tg;
            1:       return 2 * p.nb * p.tb;
            2:       return p.ty;
            default: return p.tar;
        endcase
    endfunction

    function automatic mstate_t mstep(mstate_t s, mparam_t p, bit r, bit xa, bit xb, bit nt);
        mstate_t n;
        bit      done;
        n = s;
        if (r) begin
            n.ph = 0; n.t = 1; n.pa = 0; n.pb = 0;
        end else if (nt) begin
            if (s.ph != 8) begin
                n.ph = 8; n.t = 1; n.pa = 0; n.pb = 0;
            end else begin
                n.t = s.t + 1;
            end
        end else if (s.ph == 8) begin
            n.ph = 7; n.t = 1;
        end else begin
            n.pa = s.pa | (xa && s.ph != 0);
            n.pb = s.pb | (xb && s.ph != 4);
            done = (s.t == phase_dur(s.ph, p)) ||
                   (s.ph == 0 && s.pb && s.t >= p.tmin) ||
                   (s.ph == 4 && s.pa && s.t >= p.tmin);
            if (done) begin
                n.ph = (s.ph + 1) % 8;
                n.t  = 1;
                if (n.ph == 0) n.pa = 0;
                if (n.ph == 4) n.pb = 0;
            end else begin
                n.t = s.t + 1;
            end
        end
        return n;
    endfunction

    function automatic logic [9:0] mout(mstate_t s, mparam_t p);
        logic [3:0] ph4;
        logic       odd;
        ph4 = 4'(s.ph);
        odd = (((s.t - 1) / p.tb) % 2) == 1;
        case (s.ph)
            0:       return {ph4, 6'b001_100};
            1:       return {ph4, 2'b00, odd, 3'b100};
            2:       return {ph4, 6'b010_100};
            4:       return {ph4, 6'b100_001};
            5:       return {ph4, 3'b100, 2'b00, odd};
            6:       return {ph4, 6'b100_010};
            8:       return {ph4, 1'b0, ~odd, 2'b00, ~odd, 1'b0};
            default: return {ph4, 6'b100_100};
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic cycle();
        @(posedge clk);
        ms_big = mstep(ms_big, p_big, rst, pass_a, pass_b, night);
        ms_sm  = mstep(ms_sm, p_sm, rst, pass_a, pass_b, night);
        #1;
        check("model_big", 32'(out_big), 32'(mout(ms_big, p_big)));
        check("model_small", 32'(out_sm), 32'(mout(ms_sm, p_sm)));
    endtask

    task automatic wait_phase(input logic [3:0] p, input int budget);
        int n = 0;
        while (phase_b != p && n < budget) begin
            cycle();
            n++;
        end
        check("wait_phase", 32'(phase_b), 32'(p));
    endtask

    task automatic run_len(input logic [3:0] p, output int n);
        n = 0;
        while (phase_b == p && n < 5000) begin
            cycle();
            n++;
        end
    endtask

    initial begin
        int n;
        int exp_dur[8];

        p_big = '{1024, 128, 128, 2, 512, 64};
        p_sm  = '{5, 3, 2, 1, 3, 2};
        ms_big = '{0, 1, 1'b0, 1'b0};
        ms_sm  = '{0, 1, 1'b0, 1'b0};

        // {rst, pass_a, pass_b, night, cycles, {phase, a_r a_y a_g b_r b_y b_g}} for dut_sm
        tbl[0]  = '{1, 0, 0, 0, 1, {4'd0, 6'b001_100}};
        tbl[1]  = '{0, 0, 0, 0, 4, {4'd0, 6'b001_100}};
        tbl[2]  = '{0, 0, 0, 0, 1, {4'd1, 6'b000_100}};
        tbl[3]  = '{0, 0, 0, 0, 2, {4'd1, 6'b001_100}};
        tbl[4]  = '{0, 0, 0, 0, 2, {4'd2, 6'b010_100}};
        tbl[5]  = '{0, 0, 0, 0, 3, {4'd3, 6'b100_100}};
        tbl[6]  = '{0, 0, 0, 0, 2, {4'd4, 6'b100_001}};
        tbl[7]  = '{0, 1, 0, 0, 1, {4'd4, 6'b100_001}};
        tbl[8]  = '{0, 0, 0, 0, 1, {4'd4, 6'b100_001}};
        tbl[9]  = '{0, 0, 0, 0, 1, {4'd5, 6'b100_000}};
        tbl[10] = '{0, 0, 0, 1, 1, {4'd8, 6'b010_010}};
        tbl[11] = '{0, 0, 0, 1, 2, {4'd8, 6'b000_000}};
        tbl[12] = '{0, 0, 0, 0, 1, {4'd7, 6'b100_100}};
        tbl[13] = '{0, 0, 0, 0, 2, {4'd0, 6'b001_100}};
        tbl[14] = '{0, 1, 1, 0, 3, {4'd1, 6'b000_100}};
        tbl[15] = '{1, 0, 0, 0, 1, {4'd0, 6'b001_100}};

        for (int i = 0; i < 16; i++) begin
            rst = tbl[i].r; pass_a = tbl[i].xa; pass_b = tbl[i].xb; night = tbl[i].nt;
            repeat (tbl[i].n) cycle();
            check($sformatf("table[%0d]", i), 32'(out_sm), 32'(tbl[i].exp));
        end
        rst = 0; pass_a = 0; pass_b = 0; night = 0;

        // Free run from reset: a_g counted including the reset edge, then each phase length.
        rst = 1;
        cycle();
        rst = 0;
        check("reset_out", 32'(out_big), 32'({4'd0, 6'b001_100}));
        n = 1;
        while (a_g_b && n < 5000) begin
            cycle();
            if (a_g_b) n++;
        end
        check("a_green_len", 32'(n), 32'd1024);
        exp_dur = '{1024, 512, 512, 64, 1024, 512, 512, 64};
        for (int p = 1; p < 8; p++) begin
            run_len(4'(p), n);
            check($sformatf("phase%0d_len", p), 32'(n), 32'(exp_dur[p]));
        end
        check("wrap_to_a", 32'(phase_b), 32'd0);

        // pass_a pulse at B_GREEN cnt=10 cuts the side green at cnt=128.
        wait_phase(4'd4, 5000);
        repeat (9) cycle();
        pass_a = 1;
        cycle();
        pass_a = 0;
        run_len(4'd4, n);
        check("b_green_cut", 32'(n + 10), 32'd128);

        // pass_b held from A_GREEN cnt=500; pass_a in A_GREEN must not latch.
        wait_phase(4'd0, 5000);
        repeat (499) cycle();
        pass_b = 1;
        pass_a = 1;
        run_len(4'd0, n);
        check("a_green_cut", 32'(n), 32'd2);
        pass_b = 0;
        pass_a = 0;
        wait_phase(4'd4, 5000);
        run_len(4'd4, n);
        check("b_green_full", 32'(n), 32'd1024);

        // Night entered mid A_YELLOW, then released into a full all-red.
        wait_phase(4'd2, 5000);
        repeat (100) cycle();
        night = 1;
        cycle();
        check("night_entry", 32'(out_big), 32'({4'd8, 6'b010_010}));
        repeat (128) cycle();
        check("night_off", 32'(out_big), 32'({4'd8, 6'b000_000}));
        repeat (200) cycle();
        night = 0;
        cycle();
        run_len(4'd7, n);
        check("night_red2", 32'(n), 32'd64);
        check("after_night", 32'(out_big), 32'({4'd0, 6'b001_100}));

        // Reset mid B_BLINK.
        wait_phase(4'd5, 5000);
        repeat (50) cycle();
        rst = 1;
        cycle();
        rst = 0;
        check("rst_mid_blink", 32'(out_big), 32'({4'd0, 6'b001_100}));

        for (int i = 0; i < 8000; i++) begin
            pass_a = ($urandom_range(0, 99) < 3);
            pass_b = ($urandom_range(0, 99) < 3);
            if ($urandom_range(0, 599) == 0) night = ~night;
            rst = ($urandom_range(0, 2999) == 0);
            cycle();
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
